menu_input_ctl: RTL and testbench

- Produces the menu state that the menu renderer consumes: `difficulty`, `color1` and `color2`.
- Also issues the start-of-game request to the game core.
- Takes three raw push-buttons, then synchronizes, debounces and edge-detects them.
- Runs the menu navigation FSM, which toggles between MENU and PLAYING.
- Sits on the pixel clock domain, between the board button pins and both the menu renderer and the game logic.

---
 rtl/menu_input_ctl_if.sv | 24 ++
 rtl/menu_input_ctl.sv | 145 ++++++++++++++
 tb/tb_menu_input_ctl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/menu_input_ctl_if.sv
// Bundles the board buttons, the game-over pulse and the menu state that is
// shared between the menu controller, the menu renderer and the game core.
interface menu_input_ctl_if;
  logic        btn_up;
  logic        btn_down;
  logic        btn_select;
  logic        game_over;
  logic [1:0]  cursor;
  logic        difficulty;
  logic [11:0] color1;
  logic [11:0] color2;
  logic        start_game;
  logic        game_active;

  modport master (
    output btn_up, btn_down, btn_select, game_over,
    input  cursor, difficulty, color1, color2, start_game, game_active
  );

  modport slave (
    input  btn_up, btn_down, btn_select, game_over,
    output cursor, difficulty, color1, color2, start_game, game_active
  );
endinterface

// File: rtl/menu_input_ctl.sv
// Menu controller: syncs, debounces and edge-detects three buttons, then runs the MENU/PLAYING FSM.
// Press pulse lands DEBOUNCE_CYCLES+3 clocks after the sampling edge; no backpressure, all outputs registered.
module menu_input_ctl #(
  parameter int DEBOUNCE_CYCLES = 650000,
  parameter int CNT_W           = 20
) (
  input logic          clk,
  input logic          rst,
  menu_input_ctl_if.slave bus
);

  typedef enum logic {
    MENU    = 1'b0,
    PLAYING = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int BTN_UP  = 0;
  localparam int BTN_DN  = 1;
  localparam int BTN_SEL = 2;

  logic [2:0]       raw;
  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [2:0]       db;
  logic [2:0]       lvl_q;
  logic [2:0]       lvl_q2;
  logic [2:0]       press;
  logic [CNT_W-1:0] cnt [3];

  state_t      state;
  logic [1:0]  cursor;
  logic [1:0]  cur_norm;
  logic        difficulty;
  logic [1:0]  pal_idx;
  logic [11:0] color1;
  logic [11:0] color2;
  logic        start_game;
  logic        game_active;

  assign raw = {bus.btn_select, bus.btn_down, bus.btn_up};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      db     <= '0;
      lvl_q  <= '0;
      lvl_q2 <= '0;
      press  <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      // Any sample matching the debounced level restarts the count.
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] != db[i]) begin
          if (cnt[i] == CNT_LAST) begin
            db[i]  <= sync2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
      lvl_q  <= db;
      lvl_q2 <= lvl_q;
      press  <= lvl_q & ~lvl_q2;
    end
  end

  // The unreachable cursor value 3 navigates as if it were START.
  always_comb begin
    cur_norm = cursor;
    if (cursor == 2'd3) begin
      cur_norm = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= MENU;
      cursor      <= 2'd0;
      difficulty  <= 1'b0;
      pal_idx     <= 2'd0;
      start_game  <= 1'b0;
      game_active <= 1'b0;
    end else begin
      start_game <= 1'b0;
      case (state)
        MENU: begin
          if (press[BTN_SEL]) begin
            case (cur_norm)
              2'd0: begin
                start_game  <= 1'b1;
                game_active <= 1'b1;
                state       <= PLAYING;
              end
              2'd1:    difficulty <= ~difficulty;
              default: pal_idx    <= pal_idx + 2'd1;
            endcase
          end else if (press[BTN_UP] && !press[BTN_DN]) begin
            cursor <= (cur_norm == 2'd0) ? 2'd2 : cur_norm - 2'd1;
          end else if (press[BTN_DN] && !press[BTN_UP]) begin
            cursor <= (cur_norm == 2'd2) ? 2'd0 : cur_norm + 2'd1;
          end
        end
        PLAYING: begin
          if (bus.game_over) begin
            state       <= MENU;
            game_active <= 1'b0;
            cursor      <= 2'd0;
          end
        end
        default: state <= MENU;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      color1 <= 12'hFFF;
      color2 <= 12'h000;
    end else begin
      case (pal_idx)
        2'd0: begin color1 <= 12'hFFF; color2 <= 12'h000; end
        2'd1: begin color1 <= 12'h0F0; color2 <= 12'h000; end
        2'd2: begin color1 <= 12'hFF0; color2 <= 12'h00F; end
        default: begin color1 <= 12'h000; color2 <= 12'hFFF; end
      endcase
    end
  end

  assign bus.cursor      = cursor;
  assign bus.difficulty  = difficulty;
  assign bus.color1      = color1;
  assign bus.color2      = color2;
  assign bus.start_game  = start_game;
  assign bus.game_active = game_active;

endmodule

// File: tb/tb_menu_input_ctl.sv
// Directed bench for menu_input_ctl with a short debounce window.
module tb_menu_input_ctl;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  menu_input_ctl_if bus ();

  menu_input_ctl #(.DEBOUNCE_CYCLES(DB), .CNT_W(3)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_btn(input logic [2:0] m);
    bus.btn_up     = m[0];
    bus.btn_down   = m[1];
    bus.btn_select = m[2];
  endtask

  // Hold through the FSM edge, release and let the release debounce settle.
  task automatic press(input logic [2:0] m);
    @(negedge clk);
    set_btn(m);
    repeat (DB + 5) @(posedge clk);
    @(negedge clk);
    set_btn(3'b000);
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [1:0] cur, input logic diff,
                           input logic [11:0] c1, input logic [11:0] c2,
                           input logic sg, input logic ga);
    check({tag, ".cursor"}, {10'd0, bus.cursor}, {10'd0, cur});
    check({tag, ".difficulty"}, {11'd0, bus.difficulty}, {11'd0, diff});
    check({tag, ".color1"}, bus.color1, c1);
    check({tag, ".color2"}, bus.color2, c2);
    check({tag, ".start_game"}, {11'd0, bus.start_game}, {11'd0, sg});
    check({tag, ".game_active"}, {11'd0, bus.game_active}, {11'd0, ga});
  endtask

  initial begin
    set_btn(3'b000);
    bus.game_over = 1'b0;
    #2 rst = 1'b1;
    #2 check_all("reset", 2'd0, 1'b0, 12'hFFF, 12'h000, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);

    // Glitch of three clocks is rejected.
    @(negedge clk) set_btn(3'b010);
    repeat (3) @(negedge clk);
    set_btn(3'b000);
    repeat (15) @(posedge clk);
    #1 check("glitch.cursor", {10'd0, bus.cursor}, 12'd0);

    // Held press: cursor moves on the eighth edge after the sampling edge.
    @(negedge clk) set_btn(3'b010);
    repeat (DB + 4) @(posedge clk);
    #1 check("lat.before", {10'd0, bus.cursor}, 12'd0);
    @(posedge clk);
    #1 check("lat.at", {10'd0, bus.cursor}, 12'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) set_btn(3'b000);
    repeat (12) @(posedge clk);
    #1 check("lat.release", {10'd0, bus.cursor}, 12'd1);

    press(3'b001); check("nav.up0", {10'd0, bus.cursor}, 12'd0);
    press(3'b001); check("nav.up_wrap", {10'd0, bus.cursor}, 12'd2);
    press(3'b010); check("nav.dn_wrap", {10'd0, bus.cursor}, 12'd0);
    press(3'b010); check("nav.dn1", {10'd0, bus.cursor}, 12'd1);
    press(3'b010); check("nav.dn2", {10'd0, bus.cursor}, 12'd2);
    press(3'b010); check("nav.dn3", {10'd0, bus.cursor}, 12'd0);
    press(3'b010); check("nav.dn4", {10'd0, bus.cursor}, 12'd1);

    press(3'b100); check("diff.on", {11'd0, bus.difficulty}, 12'd1);
    press(3'b100); check("diff.off", {11'd0, bus.difficulty}, 12'd0);

    press(3'b011); check("updown.cursor", {10'd0, bus.cursor}, 12'd1);
    press(3'b110);
    check("seldn.diff", {11'd0, bus.difficulty}, 12'd1);
    check("seldn.cursor", {10'd0, bus.cursor}, 12'd1);

    press(3'b010); check("pal.cursor", {10'd0, bus.cursor}, 12'd2);
    press(3'b100); check("pal1.c1", bus.color1, 12'h0F0); check("pal1.c2", bus.color2, 12'h000);
    press(3'b100); check("pal2.c1", bus.color1, 12'hFF0); check("pal2.c2", bus.color2, 12'h00F);
    press(3'b100); check("pal3.c1", bus.color1, 12'h000); check("pal3.c2", bus.color2, 12'hFFF);
    press(3'b100); check("pal0.c1", bus.color1, 12'hFFF); check("pal0.c2", bus.color2, 12'h000);
    press(3'b100); check("pal1b.c1", bus.color1, 12'h0F0); check("pal1b.c2", bus.color2, 12'h000);

    press(3'b010); check("start.cursor", {10'd0, bus.cursor}, 12'd0);
    @(negedge clk) set_btn(3'b100);
    repeat (DB + 4) @(posedge clk);
    #1 check("start.pre", {11'd0, bus.start_game}, 12'd0);
    @(posedge clk);
    #1 check("start.pulse", {11'd0, bus.start_game}, 12'd1);
    check("start.active", {11'd0, bus.game_active}, 12'd1);
    @(posedge clk);
    #1 check("start.one_clk", {11'd0, bus.start_game}, 12'd0);
    @(negedge clk) set_btn(3'b000);
    repeat (12) @(posedge clk);

    press(3'b001);
    press(3'b010);
    press(3'b100);
    #1 check_all("playing", 2'd0, 1'b1, 12'h0F0, 12'h000, 1'b0, 1'b1);

    @(negedge clk) bus.game_over = 1'b1;
    @(negedge clk) bus.game_over = 1'b0;
    check_all("over", 2'd0, 1'b1, 12'h0F0, 12'h000, 1'b0, 1'b0);

    press(3'b100); check("restart.active", {11'd0, bus.game_active}, 12'd1);
    @(negedge clk) set_btn(3'b100);
    repeat (DB + 4) @(posedge clk);
    @(negedge clk) bus.game_over = 1'b1;
    @(posedge clk);
    #1 check("oversel.active", {11'd0, bus.game_active}, 12'd0);
    check("oversel.start", {11'd0, bus.start_game}, 12'd0);
    @(negedge clk) bus.game_over = 1'b0;
    set_btn(3'b000);
    @(posedge clk);
    #1 check("oversel.start2", {11'd0, bus.start_game}, 12'd0);
    check("oversel.active2", {11'd0, bus.game_active}, 12'd0);
    repeat (12) @(posedge clk);

    press(3'b100); check("replay.active", {11'd0, bus.game_active}, 12'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_all("midrst", 2'd0, 1'b0, 12'hFFF, 12'h000, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("postrst.active", {11'd0, bus.game_active}, 12'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past 200000 time units");
    $fatal(1, "timeout");
  end
endmodule
